regfile_mp: RTL and testbench

//   Architectural register file with rename status (busy flag + ROB tag per register).
//   It is the parametrised successor of the single-commit, two-read register file.

---
 rtl/regfile_mp.sv | 106 ++++++++++
 tb/tb_regfile_mp.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: register file with rename busy/tag state, NRD bypassed read ports, one dispatch port and NCM commit ports
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int TAG_W = 4,
  parameter int NRD   = 2,
  parameter int NCM   = 2,
  localparam int REG_W = $clog2(NREG)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic [NRD*REG_W-1:0] rd_idx_in,
  output logic [NRD-1:0]       rd_busy_out,
  output logic [NRD*XLEN-1:0]  rd_value_out,
  output logic [NRD*TAG_W-1:0] rd_tag_out,
  input  logic                 disp_en_in,
  input  logic [REG_W-1:0]     disp_rd_in,
  input  logic [TAG_W-1:0]     disp_tag_in,
  input  logic [NCM-1:0]       cm_en_in,
  input  logic [NCM*REG_W-1:0] cm_rd_in,
  input  logic [NCM*XLEN-1:0]  cm_value_in,
  input  logic [NCM*TAG_W-1:0] cm_tag_in,
  input  logic                 flush_in
);
  logic [XLEN-1:0]  value_q [NREG];
  logic [XLEN-1:0]  value_d [NREG];
  logic [TAG_W-1:0] tag_q   [NREG];
  logic [TAG_W-1:0] tag_d   [NREG];
  logic [NREG-1:0]  busy_q, busy_d;
  logic [REG_W-1:0] ri;
  logic [XLEN-1:0]  rv;
  logic [TAG_W-1:0] rt;
  logic             rb;

  // next state: commits in port order (younger last), then flush or dispatch overriding the busy/tag clears
  always_comb begin
    busy_d = busy_q;
    value_d = value_q;
    tag_d = tag_q;
    if (rdy_in) begin
      for (int j = 0; j < NCM; j++) begin
        if (cm_en_in[j] && cm_rd_in[j*REG_W +: REG_W] != '0) begin
          value_d[cm_rd_in[j*REG_W +: REG_W]] = cm_value_in[j*XLEN +: XLEN];
          if (tag_q[cm_rd_in[j*REG_W +: REG_W]] == cm_tag_in[j*TAG_W +: TAG_W]) begin
            busy_d[cm_rd_in[j*REG_W +: REG_W]] = 1'b0;
            tag_d[cm_rd_in[j*REG_W +: REG_W]] = '0;
          end
        end
      end
      if (flush_in) begin
        busy_d = '0;
        for (int i = 0; i < NREG; i++) tag_d[i] = '0;
      end else if (disp_en_in && disp_rd_in != '0) begin
        busy_d[disp_rd_in] = 1'b1;
        tag_d[disp_rd_in] = disp_tag_in;
      end
    end
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        value_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      value_q <= value_d;
      tag_q <= tag_d;
    end
  end

  // read ports: stored state with same-cycle commit bypass; dispatch and flush are invisible here
  always_comb begin
    rd_busy_out = '0;
    rd_value_out = '0;
    rd_tag_out = '0;
    ri = '0;
    rv = '0;
    rt = '0;
    rb = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      ri = rd_idx_in[k*REG_W +: REG_W];
      rv = value_q[ri];
      rb = busy_q[ri];
      rt = tag_q[ri];
      for (int j = 0; j < NCM; j++) begin
        if (rdy_in && cm_en_in[j] && cm_rd_in[j*REG_W +: REG_W] == ri) begin
          rv = cm_value_in[j*XLEN +: XLEN];
          if (busy_q[ri] && cm_tag_in[j*TAG_W +: TAG_W] == tag_q[ri]) begin
            rb = 1'b0;
            rt = '0;
          end
        end
      end
      if (rst_in && ri != '0) begin
        rd_busy_out[k] = rb;
        rd_value_out[k*XLEN +: XLEN] = rv;
        rd_tag_out[k*TAG_W +: TAG_W] = rt;
      end
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scoreboard bench for regfile_mp
module tb_regfile_mp;
  localparam int XLEN = 32, NREG = 32, TAG_W = 4, NRD = 2, NCM = 2, REG_W = 5;
  typedef struct {
    string name;
    int k;
    logic b;
    logic [XLEN-1:0] v;
    logic [TAG_W-1:0] t;
  } exp_t;
  logic clk = 0, rst_n = 0, rdy = 1, disp_en = 0, flush = 0;
  logic [NRD*REG_W-1:0] rd_idx = '0;
  logic [NRD-1:0] rd_busy;
  logic [NRD*XLEN-1:0] rd_value;
  logic [NRD*TAG_W-1:0] rd_tag;
  logic [REG_W-1:0] disp_rd = '0;
  logic [TAG_W-1:0] disp_tag = '0;
  logic [NCM-1:0] cm_en = '0;
  logic [NCM*REG_W-1:0] cm_rd = '0;
  logic [NCM*XLEN-1:0] cm_value = '0;
  logic [NCM*TAG_W-1:0] cm_tag = '0;
  exp_t q[$];
  int checks = 0, passed = 0;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NRD(NRD), .NCM(NCM)) dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .rd_idx_in(rd_idx), .rd_busy_out(rd_busy),
    .rd_value_out(rd_value), .rd_tag_out(rd_tag), .disp_en_in(disp_en), .disp_rd_in(disp_rd),
    .disp_tag_in(disp_tag), .cm_en_in(cm_en), .cm_rd_in(cm_rd), .cm_value_in(cm_value),
    .cm_tag_in(cm_tag), .flush_in(flush));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    disp_en = 0;
    cm_en = '0;
    flush = 0;
    rdy = 1;
  endtask

  task automatic cm(input int j, input int rd, input int tag, input logic [XLEN-1:0] val);
    cm_en[j] = 1'b1;
    cm_rd[j*REG_W +: REG_W] = rd[REG_W-1:0];
    cm_tag[j*TAG_W +: TAG_W] = tag[TAG_W-1:0];
    cm_value[j*XLEN +: XLEN] = val;
  endtask

  task automatic disp(input int rd, input int tag);
    disp_en = 1;
    disp_rd = rd[REG_W-1:0];
    disp_tag = tag[TAG_W-1:0];
  endtask

  task automatic expect_rd(input string n, input int k, input int idx, input logic b,
                           input logic [XLEN-1:0] v, input logic [TAG_W-1:0] t);
    rd_idx[k*REG_W +: REG_W] = idx[REG_W-1:0];
    q.push_back('{name: n, k: k, b: b, v: v, t: t});
  endtask

  // monitor: compare every queued expectation against the read port it names
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (rd_busy[e.k] === e.b && rd_value[e.k*XLEN +: XLEN] === e.v && rd_tag[e.k*TAG_W +: TAG_W] === e.t)
          passed++;
        else
          $display("FAIL %s: got busy=%0b value=%h tag=%0d, want busy=%0b value=%h tag=%0d", e.name,
                   rd_busy[e.k], rd_value[e.k*XLEN +: XLEN], rd_tag[e.k*TAG_W +: TAG_W], e.b, e.v, e.t);
      end
    end
  end

  initial begin
    tick();
    cm(0, 5, 0, 32'h55);
    expect_rd("reset_r5", 0, 5, 0, 0, 0);
    expect_rd("reset_r3", 1, 3, 0, 0, 0);
    tick();
    rst_n = 1;
    disp(5, 1);
    expect_rd("disp_invisible", 0, 5, 0, 0, 0);
    tick();
    expect_rd("r5_busy", 0, 5, 1, 0, 1);
    tick();
    rst_n = 0;
    expect_rd("async_reset_r5", 0, 5, 0, 0, 0);
    tick();
    rst_n = 1;
    expect_rd("after_reset_r5", 0, 5, 0, 0, 0);
    tick();
    disp(3, 7);
    tick();
    expect_rd("r3_busy", 0, 3, 1, 0, 7);
    expect_rd("r0_zero", 1, 0, 0, 0, 0);
    tick();
    cm(0, 3, 7, 32'hAB);
    expect_rd("r3_commit_bypass", 0, 3, 0, 32'hAB, 0);
    tick();
    expect_rd("r3_stored", 1, 3, 0, 32'hAB, 0);
    tick();
    disp(4, 2);
    tick();
    disp(4, 5);
    expect_rd("r4_first_tag", 0, 4, 1, 0, 2);
    tick();
    cm(0, 4, 2, 32'd9);
    expect_rd("stale_bypass", 0, 4, 1, 32'd9, 5);
    tick();
    expect_rd("stale_stored", 1, 4, 1, 32'd9, 5);
    tick();
    disp(6, 3);
    tick();
    cm(0, 6, 1, 32'd1);
    cm(1, 6, 3, 32'd3);
    expect_rd("dual_bypass", 0, 6, 0, 32'd3, 0);
    tick();
    expect_rd("dual_stored", 0, 6, 0, 32'd3, 0);
    tick();
    disp(8, 4);
    tick();
    cm(0, 8, 4, 32'h10);
    disp(8, 6);
    expect_rd("cm_disp_bypass", 0, 8, 0, 32'h10, 0);
    tick();
    expect_rd("cm_disp_stored", 0, 8, 1, 32'h10, 6);
    tick();
    disp(9, 8);
    tick();
    rdy = 0;
    flush = 1;
    cm(0, 10, 0, 32'h77);
    expect_rd("frozen_r9", 0, 9, 1, 0, 8);
    expect_rd("frozen_no_bypass", 1, 10, 0, 0, 0);
    tick();
    expect_rd("frozen_kept_r9", 0, 9, 1, 0, 8);
    expect_rd("frozen_no_write", 1, 10, 0, 0, 0);
    tick();
    flush = 1;
    disp(11, 2);
    cm(1, 0, 0, 32'hFFFF);
    expect_rd("flush_same_cycle", 0, 9, 1, 0, 8);
    expect_rd("x0_bypass", 1, 0, 0, 0, 0);
    tick();
    expect_rd("flushed_r9", 0, 9, 0, 0, 0);
    expect_rd("flush_drops_disp", 1, 11, 0, 0, 0);
    tick();
    expect_rd("flushed_r8", 0, 8, 0, 32'h10, 0);
    expect_rd("x0_stored", 1, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
